// File: rtl/ram_mm2s_reader_if.sv
// Bundle of the command, RAM read-port and AXI-Stream signals of one mm2s reader.
// master is the reader side; slave is the command source / RAM / stream sink side.
interface ram_mm2s_reader_if #(
  parameter int AXI_WIDTH      = 128,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int LEN_WIDTH      = 16,
  parameter int LSB            = $clog2(AXI_WIDTH) - 3
);
  logic                            cmd_valid;
  logic                            cmd_ready;
  logic [AXI_ADDR_WIDTH-1:0]       cmd_addr;
  logic [LEN_WIDTH-1:0]            cmd_len;
  logic                            mem_ren;
  logic [AXI_ADDR_WIDTH-LSB-1:0]   mem_addr;
  logic [AXI_WIDTH-1:0]            mem_data;
  logic                            m_axis_tvalid;
  logic                            m_axis_tready;
  logic [AXI_WIDTH-1:0]            m_axis_tdata;
  logic                            m_axis_tlast;
  logic                            done;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, mem_data, m_axis_tready,
    output cmd_ready, mem_ren, mem_addr, m_axis_tvalid, m_axis_tdata, m_axis_tlast, done
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, mem_data, m_axis_tready,
    input  cmd_ready, mem_ren, mem_addr, m_axis_tvalid, m_axis_tdata, m_axis_tlast, done
  );
endinterface

// File: rtl/ram_mm2s_reader.sv
// Turns a (base, len) command into word reads on a 1-cycle RAM port and streams the words out.
// First beat 3 cycles after command accept; a 2-entry output FIFO with read credit absorbs any tready stall.
module ram_mm2s_reader #(
  parameter int AXI_WIDTH      = 128,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int LEN_WIDTH      = 16,
  parameter int LSB            = $clog2(AXI_WIDTH) - 3
) (
  input  logic              clk,
  input  logic              rst,
  ram_mm2s_reader_if.master bus
);
  localparam int WA = AXI_ADDR_WIDTH - LSB;
  localparam logic [LEN_WIDTH:0] CNT_ONE = (LEN_WIDTH + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t               state_q, state_d;
  logic [WA-1:0]        addr_q, addr_d;
  logic [LEN_WIDTH:0]   cnt_q, cnt_d;
  logic                 inflight_q, inflight_d;
  logic                 inflight_last_q, inflight_last_d;
  logic [AXI_WIDTH-1:0] fifo_dat_q [2];
  logic [AXI_WIDTH-1:0] fifo_dat_d [2];
  logic [1:0]           fifo_last_q, fifo_last_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           occ_q, occ_d;
  logic                 done_q, done_d;

  logic       tvalid, tlast, pop, push, credit, issue;
  logic [2:0] level;
  logic       unused_addr_lsb;

  assign unused_addr_lsb = ^bus.cmd_addr[LSB-1:0];

  assign tvalid = (occ_q != 2'd0);
  assign tlast  = fifo_last_q[rd_ptr_q] & tvalid;
  assign pop    = tvalid & bus.m_axis_tready;
  assign push   = inflight_q;

  // Words already owed to the FIFO (stored + in flight) minus the one leaving this cycle must stay below 2.
  assign level  = {1'b0, occ_q} + {2'b00, inflight_q};
  assign credit = level < (3'd2 + {2'b00, pop});
  assign issue  = (state_q == S_RUN) && credit && !rst;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    cnt_d           = cnt_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    done_d          = 1'b0;
    fifo_dat_d      = fifo_dat_q;
    fifo_last_d     = fifo_last_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    occ_d           = occ_q + {1'b0, push} - {1'b0, pop};

    if (push) begin
      fifo_dat_d[wr_ptr_q]  = bus.mem_data;
      fifo_last_d[wr_ptr_q] = inflight_last_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (issue) begin
      inflight_d      = 1'b1;
      inflight_last_d = (cnt_q == CNT_ONE);
      addr_d          = addr_q + 1'b1;
      cnt_d           = cnt_q - CNT_ONE;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          addr_d  = bus.cmd_addr[AXI_ADDR_WIDTH-1:LSB];
          cnt_d   = {1'b0, bus.cmd_len} + CNT_ONE;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (issue && (cnt_q == CNT_ONE)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && tlast) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      cnt_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_dat_q      <= '{default: '0};
      fifo_last_q     <= '0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      occ_q           <= '0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      cnt_q           <= cnt_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      fifo_dat_q      <= fifo_dat_d;
      fifo_last_q     <= fifo_last_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      occ_q           <= occ_d;
      done_q          <= done_d;
    end
  end

  assign bus.cmd_ready     = (state_q == S_IDLE);
  assign bus.mem_ren       = issue;
  assign bus.mem_addr      = addr_q;
  assign bus.m_axis_tvalid = tvalid;
  assign bus.m_axis_tdata  = fifo_dat_q[rd_ptr_q];
  assign bus.m_axis_tlast  = tlast;
  assign bus.done          = done_q;
endmodule

// File: tb/tb_ram_mm2s_reader.sv
// Directed bench for ram_mm2s_reader: RAM word at address a holds a+1; events are logged per cycle and checked.
module tb_ram_mm2s_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_mm2s_reader_if bus ();
  ram_mm2s_reader dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [127:0] ram_word(input logic [27:0] a);
    return {100'h0, a} + 128'd1;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_ren) bus.mem_data <= ram_word(bus.mem_addr);
    else             bus.mem_data <= {4{32'hDEADBEEF}};
  end

  int           cyc = 0;
  int           hs_cyc[$];
  int           ren_cyc[$];
  logic [27:0]  ren_addr[$];
  int           beat_cyc[$];
  logic [127:0] beat_dat[$];
  logic         beat_last[$];
  int           done_cyc[$];
  int           stall_viol = 0;
  int           credit_viol = 0;
  int           outstanding = 0;
  logic         prev_stall = 1'b0;
  logic [127:0] prev_dat = '0;
  logic         prev_last = 1'b0;

  // Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (bus.cmd_valid && bus.cmd_ready) hs_cyc.push_back(cyc);
      if (bus.mem_ren) begin
        ren_cyc.push_back(cyc);
        ren_addr.push_back(bus.mem_addr);
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        beat_cyc.push_back(cyc);
        beat_dat.push_back(bus.m_axis_tdata);
        beat_last.push_back(bus.m_axis_tlast);
      end
      if (bus.done) done_cyc.push_back(cyc);
      if (prev_stall && (!bus.m_axis_tvalid || bus.m_axis_tdata !== prev_dat ||
                         bus.m_axis_tlast !== prev_last))
        stall_viol++;
      outstanding = outstanding + int'(bus.mem_ren) - int'(bus.m_axis_tvalid && bus.m_axis_tready);
      if (outstanding > 2) credit_viol++;
    end else begin
      outstanding = 0;
    end
    prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready && !rst;
    prev_dat   = bus.m_axis_tdata;
    prev_last  = bus.m_axis_tlast;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    hs_cyc.delete(); ren_cyc.delete(); ren_addr.delete();
    beat_cyc.delete(); beat_dat.delete(); beat_last.delete(); done_cyc.delete();
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [15:0] l);
    int n;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    bus.cmd_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.cmd_valid && bus.cmd_ready) && n < 200);
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget, input bit rnd);
    for (int i = 0; i < budget && done_cyc.size() < n; i++) begin
      step();
      if (rnd) bus.m_axis_tready = ($urandom_range(0, 9) < 3);
    end
    bus.m_axis_tready = 1'b1;
    check("done_count", 128'(done_cyc.size()), 128'(n));
  endtask

  initial begin
    bus.cmd_valid     = 1'b0;
    bus.cmd_addr      = '0;
    bus.cmd_len       = '0;
    bus.m_axis_tready = 1'b1;
    bus.mem_data      = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 128'(bus.cmd_ready), 128'd1);
    check("rst_mem_ren",   128'(bus.mem_ren), 128'd0);
    check("rst_mem_addr",  128'(bus.mem_addr), 128'd0);
    check("rst_tvalid",    128'(bus.m_axis_tvalid), 128'd0);
    check("rst_tlast",     128'(bus.m_axis_tlast), 128'd0);
    check("rst_tdata",     bus.m_axis_tdata, 128'd0);
    check("rst_done",      128'(bus.done), 128'd0);
    step();
    rst = 1'b0;
    step();

    // Single beat at byte 0x100 -> word 0x10.
    clear_logs();
    send_cmd(32'h100, 16'd0);
    wait_done(1, 50, 1'b0);
    check("s_ren_n",    128'(ren_cyc.size()), 128'd1);
    check("s_ren_addr", 128'(ren_addr[0]), 128'h10);
    check("s_ren_cyc",  128'(ren_cyc[0] - hs_cyc[0]), 128'd1);
    check("s_beat_n",   128'(beat_dat.size()), 128'd1);
    check("s_beat_dat", beat_dat[0], 128'h11);
    check("s_beat_lst", 128'(beat_last[0]), 128'd1);
    check("s_beat_cyc", 128'(beat_cyc[0] - hs_cyc[0]), 128'd3);
    check("s_done_cyc", 128'(done_cyc[0] - hs_cyc[0]), 128'd4);

    // Full rate, 4 beats from word 0.
    clear_logs();
    send_cmd(32'h0, 16'd3);
    wait_done(1, 50, 1'b0);
    check("f_ren_n",  128'(ren_cyc.size()), 128'd4);
    check("f_beat_n", 128'(beat_dat.size()), 128'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("f_ren_cyc%0d", i),  128'(ren_cyc[i] - hs_cyc[0]), 128'(i + 1));
      check($sformatf("f_ren_addr%0d", i), 128'(ren_addr[i]), 128'(i));
      check($sformatf("f_beat_dat%0d", i), beat_dat[i], 128'(i + 1));
      check($sformatf("f_beat_cyc%0d", i), 128'(beat_cyc[i] - hs_cyc[0]), 128'(i + 3));
      check($sformatf("f_beat_lst%0d", i), 128'(beat_last[i]), 128'(i == 3));
    end
    check("f_done_cyc", 128'(done_cyc[0] - hs_cyc[0]), 128'd7);

    // Backpressure: 16 beats from word 0x20, tready ~30%.
    clear_logs();
    stall_viol  = 0;
    credit_viol = 0;
    bus.m_axis_tready = 1'b0;
    send_cmd(32'h200, 16'd15);
    wait_done(1, 1000, 1'b1);
    check("b_beat_n", 128'(beat_dat.size()), 128'd16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("b_beat_dat%0d", i), beat_dat[i], 128'(32'h21 + i));
      check($sformatf("b_beat_lst%0d", i), 128'(beat_last[i]), 128'(i == 15));
    end
    check("b_stall_stable", 128'(stall_viol), 128'd0);
    check("b_credit",       128'(credit_viol), 128'd0);

    // Back-to-back: second command held valid while the first runs.
    clear_logs();
    send_cmd(32'h400, 16'd2);
    bus.cmd_addr  = 32'h800;
    bus.cmd_len   = 16'd1;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 100 && hs_cyc.size() < 2; i++) step();
    bus.cmd_valid = 1'b0;
    wait_done(2, 100, 1'b0);
    check("bb_hs_n",    128'(hs_cyc.size()), 128'd2);
    check("bb_hs_at_done", 128'(hs_cyc[1]), 128'(done_cyc[0]));
    check("bb_done0",   128'(done_cyc[0] - hs_cyc[0]), 128'd6);
    check("bb_beat_n",  128'(beat_dat.size()), 128'd5);
    check("bb_b3_cyc",  128'(beat_cyc[3] - hs_cyc[1]), 128'd3);
    check("bb_done1",   128'(done_cyc[1] - hs_cyc[1]), 128'd5);
    check("bb_dat0", beat_dat[0], 128'h41);
    check("bb_dat2", beat_dat[2], 128'h43);
    check("bb_dat3", beat_dat[3], 128'h81);
    check("bb_dat4", beat_dat[4], 128'h82);
    check("bb_lst1", 128'(beat_last[1]), 128'd0);
    check("bb_lst2", 128'(beat_last[2]), 128'd1);
    check("bb_lst3", 128'(beat_last[3]), 128'd0);
    check("bb_lst4", 128'(beat_last[4]), 128'd1);

    // Wrap from the last word of the address space.
    clear_logs();
    send_cmd(32'hFFFF_FFF0, 16'd2);
    wait_done(1, 50, 1'b0);
    check("w_ren_n", 128'(ren_addr.size()), 128'd3);
    check("w_addr0", 128'(ren_addr[0]), 128'h0FFF_FFFF);
    check("w_addr1", 128'(ren_addr[1]), 128'h0);
    check("w_addr2", 128'(ren_addr[2]), 128'h1);
    check("w_dat0",  beat_dat[0], 128'h1000_0000);
    check("w_dat1",  beat_dat[1], 128'h1);
    check("w_lst2",  128'(beat_last[2]), 128'd1);

    // Reset during beat 3 of an 8-beat command.
    clear_logs();
    send_cmd(32'h300, 16'd7);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("r_tvalid",    128'(bus.m_axis_tvalid), 128'd0);
    check("r_mem_ren",   128'(bus.mem_ren), 128'd0);
    check("r_cmd_ready", 128'(bus.cmd_ready), 128'd1);
    check("r_done",      128'(bus.done), 128'd0);
    check("r_beats_pre", 128'(beat_dat.size()), 128'd2);
    repeat (10) step();
    check("r_no_done",   128'(done_cyc.size()), 128'd0);
    check("r_no_beats",  128'(beat_dat.size()), 128'd2);

    clear_logs();
    send_cmd(32'h500, 16'd1);
    wait_done(1, 50, 1'b0);
    check("r2_beat_n", 128'(beat_dat.size()), 128'd2);
    check("r2_dat0",   beat_dat[0], 128'h51);
    check("r2_dat1",   beat_dat[1], 128'h52);
    check("r2_lst0",   128'(beat_last[0]), 128'd0);
    check("r2_lst1",   128'(beat_last[1]), 128'd1);
    check("r2_done",   128'(done_cyc[0] - hs_cyc[0]), 128'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
